// File: rtl/zprize_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Metadata rides alongside the operands and is presented with the result.
module zprize_div_seq #(
    parameter int WN = 768,
    parameter int WD = 384,
    parameter int M  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    input  logic [M-1:0]  m_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WN-1:0] quot,
    output logic [WD-1:0] rem,
    output logic          div0,
    output logic [M-1:0]  m_o
);
    localparam int CW = $clog2(WN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic          rdy_q;
    logic [WN-1:0] sh;      // dividend bits shift out the top, quotient bits enter the bottom
    logic [WD-1:0] dvs;
    logic [WD-1:0] r;
    logic [CW-1:0] cnt;
    logic [M-1:0]  m_q;
    logic          d0_q;

    logic [WD:0]   t;
    logic          ge;
    logic [WD-1:0] r_nxt;
    logic [WN-1:0] q_nxt;
    logic          last;
    logic          accept;
    logic          handshake;

    always_comb begin
        t      = {r, sh[WN-1]};
        ge     = (t >= {1'b0, dvs});
        r_nxt  = WD'(ge ? (t - {1'b0, dvs}) : t);
        q_nxt  = {sh[WN-2:0], ge};
        last   = (cnt == CW'(WN - 1));
    end

    assign accept    = rdy_q && in_valid;
    assign handshake = (state == S_DONE) && out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rdy_q <= 1'b0;
            sh    <= '0;
            dvs   <= '0;
            r     <= '0;
            cnt   <= '0;
            m_q   <= '0;
            d0_q  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            div0  <= 1'b0;
            m_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rdy_q <= !accept;
                    if (accept) begin
                        sh    <= dividend;
                        dvs   <= divisor;
                        m_q   <= m_i;
                        d0_q  <= (divisor == '0);
                        r     <= '0;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    sh  <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt + 1'b1;
                    // Outputs only move on the final iteration so they hold during BUSY.
                    if (last) begin
                        quot  <= q_nxt;
                        rem   <= r_nxt;
                        div0  <= d0_q;
                        m_o   <= m_q;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (handshake) begin
                        state <= S_IDLE;
                        rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zprize_div_seq.sv
// Directed bench: a small 16/8 instance for corner cases and handshakes,
// plus a default-width instance fed a*b+c products with known quotient/remainder.
module tb_zprize_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_iv = 0, s_ir, s_ov, s_or = 0, s_d0;
    logic [15:0] s_dvd = '0, s_q;
    logic [7:0]  s_dvs = '0, s_mi = '0, s_r, s_mo;

    logic         b_iv = 0, b_ir, b_ov, b_or = 0, b_d0;
    logic [767:0] b_dvd = '0, b_q;
    logic [383:0] b_dvs = '0, b_r;
    logic [31:0]  b_mi = '0, b_mo;

    int n_cmp  = 0;
    int n_fail = 0;

    zprize_div_seq #(.WN(16), .WD(8), .M(8)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
        .dividend(s_dvd), .divisor(s_dvs), .m_i(s_mi),
        .out_valid(s_ov), .out_ready(s_or), .quot(s_q), .rem(s_r),
        .div0(s_d0), .m_o(s_mo)
    );

    zprize_div_seq u_big (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
        .dividend(b_dvd), .divisor(b_dvs), .m_i(b_mi),
        .out_valid(b_ov), .out_ready(b_or), .quot(b_q), .rem(b_r),
        .div0(b_d0), .m_o(b_mo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_go(input logic [15:0] dvd, input logic [7:0] dvs, input logic [7:0] m);
        int n = 0;
        while (!s_ir && n < 50) begin tick(); n++; end
        check("s_ready_before_accept", s_ir, 1);
        s_dvd = dvd; s_dvs = dvs; s_mi = m; s_iv = 1;
        tick();
        s_iv = 0; s_dvd = 16'hDEAD; s_dvs = 8'h5A; s_mi = 8'h00;
    endtask

    task automatic s_wait(output int lat);
        lat = 0;
        while (!s_ov && lat < 100) begin tick(); lat++; end
    endtask

    task automatic s_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] m, input logic [15:0] eq, input logic [7:0] er,
                        input logic ed0);
        int lat;
        s_go(dvd, dvs, m);
        s_wait(lat);
        check({tag, "_latency"}, 768'(lat), 768'(16));
        check({tag, "_quot"}, s_q, eq);
        check({tag, "_rem"}, s_r, er);
        check({tag, "_div0"}, s_d0, ed0);
        check({tag, "_m_o"}, s_mo, m);
        s_or = 1;
        tick();
        s_or = 0;
        check({tag, "_ov_after_hs"}, s_ov, 0);
        check({tag, "_ready_after_hs"}, s_ir, 1);
    endtask

    function automatic logic [383:0] r384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int lat;
        int acc[3];
        int na;
        bit bad;
        logic [15:0] sq;
        logic [7:0]  sr, sm;
        logic [383:0] a, b, c;
        logic [767:0] prod;

        // Reset state
        tick(); tick();
        check("rst_in_ready", s_ir, 0);
        check("rst_out_valid", s_ov, 0);
        check("rst_quot", s_q, 0);
        check("rst_rem", s_r, 0);
        check("rst_div0", s_d0, 0);
        check("rst_m_o", s_mo, 0);
        check("rst_big_in_ready", b_ir, 0);
        rst = 0;
        tick();
        check("post_rst_in_ready", s_ir, 1);
        check("post_rst_big_in_ready", b_ir, 1);

        // Directed small-width divisions
        s_op("d1000_7", 16'd1000, 8'd7, 8'hA5, 16'd142, 8'd6, 0);
        s_op("d65535_255", 16'd65535, 8'd255, 8'h11, 16'd257, 8'd0, 0);
        s_op("d5_9", 16'd5, 8'd9, 8'h22, 16'd0, 8'd5, 0);
        s_op("d1234_1", 16'h1234, 8'd1, 8'h33, 16'h1234, 8'd0, 0);
        s_op("div0", 16'h0312, 8'd0, 8'h44, 16'hFFFF, 8'h12, 1);

        // Backpressure: hold the result for 20 cycles while poking in_valid
        s_go(16'd48879, 8'd17, 8'h3C);
        s_wait(lat);
        check("bp_latency", 768'(lat), 768'(16));
        sq = s_q; sr = s_r; sm = s_mo;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            s_iv = 1; s_dvd = 16'(i * 97); s_dvs = 8'(i + 3); s_mi = 8'(i);
            tick();
            if (!s_ov || s_ir || s_q !== sq || s_r !== sr || s_mo !== sm || s_d0 !== 1'b0) bad = 1;
        end
        s_iv = 0;
        check("bp_held_stable", bad, 0);
        check("bp_quot", s_q, 16'd2875);
        check("bp_rem", s_r, 8'd4);
        check("bp_m_o", s_mo, 8'h3C);
        s_or = 1;
        tick();
        s_or = 0;
        check("bp_ready_after_hs", s_ir, 1);
        check("bp_ov_after_hs", s_ov, 0);

        // Back-to-back issue with out_ready held high
        s_dvd = 16'd1000; s_dvs = 8'd7; s_mi = 8'h77;
        s_iv = 1; s_or = 1; na = 0;
        for (int i = 0; i < 45; i++) begin
            if (s_ir && na < 3) begin acc[na] = i; na++; end
            tick();
        end
        s_iv = 0;
        check("b2b_accepts", 768'(na), 768'(3));
        check("b2b_interval0", 768'(acc[1] - acc[0]), 768'(18));
        check("b2b_interval1", 768'(acc[2] - acc[1]), 768'(18));
        lat = 0;
        while (!s_ir && lat < 100) begin tick(); lat++; end
        s_or = 0;
        check("b2b_drained", s_ir, 1);
        check("b2b_quot", s_q, 16'd142);
        check("b2b_rem", s_r, 8'd6);

        // Reset in the middle of an operation
        s_go(16'd1000, 8'd7, 8'h99);
        for (int i = 0; i < 6; i++) tick();
        rst = 1;
        tick();
        check("midrst_ready_low", s_ir, 0);
        check("midrst_ov_low", s_ov, 0);
        rst = 0;
        tick();
        check("midrst_ready_after", s_ir, 1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (s_ov) bad = 1; end
        check("midrst_no_out_valid", bad, 0);
        s_op("d200_13", 16'd200, 8'd13, 8'h5E, 16'd15, 8'd5, 0);

        // Default widths: dividend = a*b + c with c < b, so quot = a and rem = c
        for (int k = 0; k < 40; k++) begin
            a = r384();
            b = r384() >> $urandom_range(0, 380);
            if (b == '0) b = 384'd1;
            c = (k % 2 == 1) ? (r384() % b) : '0;
            prod = {384'd0, a} * {384'd0, b} + {384'd0, c};
            lat = 0;
            while (!b_ir && lat < 50) begin tick(); lat++; end
            b_dvd = prod; b_dvs = b; b_mi = 32'(k) ^ 32'hC0DE0000; b_iv = 1;
            tick();
            b_iv = 0;
            lat = 0;
            while (!b_ov && lat < 900) begin tick(); lat++; end
            check("big_latency", 768'(lat), 768'(768));
            check("big_quot", b_q, {384'd0, a});
            check("big_rem", {384'd0, b_r}, {384'd0, c});
            check("big_m_o", b_mo, 32'(k) ^ 32'hC0DE0000);
            check("big_div0", b_d0, 0);
            b_or = 1;
            tick();
            b_or = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/zprize_div_seq.md
# zprize_div_seq

Sequential restoring divider: the inverse of the wide multipliers in the MSM datapath. Takes a WN-bit dividend (typically a full W0+W1 product) and a WD-bit divisor and returns quotient and remainder, one quotient bit per clock. A per-operation metadata word (M bits) rides alongside, like the `m_i`/`m_o` sideband on the multipliers. Intended for low-rate paths (constant precomputation, result normalisation, self-check of multiplier outputs), so area matters more than throughput.

## Interface
Parameters:
- WN, 768, dividend and quotient width (≥2)
- WD, 384, divisor and remainder width (1 ≤ WD ≤ WN)
- M, 32, metadata sideband width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept; high only in IDLE
- dividend  in  WN  numerator, unsigned
- divisor  in  WD  denominator, unsigned
- m_i  in  M  metadata, captured with operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- quot  out  WN  quotient
- rem  out  WD  remainder
- div0  out  1  divisor was zero
- m_o  out  M  metadata captured at accept

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. If in_valid, then on that edge: latch dividend into shift register, divisor into a register, m_i, and div0=(divisor==0); clear partial remainder (WD+1 bits) and iteration counter; go to BUSY.
- BUSY, one iteration per edge, MSB of dividend first:
  - t = {r[WD-1:0], next dividend bit}.
  - If t ≥ divisor: r=t−divisor and shift in a quotient bit of 1; otherwise r=t and shift in 0.
  - Counter increments.
  - The edge completing iteration WN enters DONE.
- All comparisons and subtractions are unsigned at WD+1 bits. The remainder is always < divisor, so it fits WD bits.
- div0 case: the iterations still run, giving quot = all ones and rem = dividend mod 2^WD. div0=1.
- DONE: out_valid=1; quot, rem, div0 and m_o stay stable. When out_ready=1, go to IDLE on that edge.
- in_valid is ignored outside IDLE. Operands need to be stable only on the accepting edge.
- rst=1 at any edge, including mid-BUSY or in DONE: go to IDLE and discard the operation; no output handshake follows.

## Timing
- Reset values: out_valid=0, quot=0, rem=0, div0=0, m_o=0. in_ready=0 while rst is high, and 1 from the first cycle after rst is deasserted.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- Latency: accept at edge E0 means out_valid is high after edge E0+WN.
- Output handshake at edge Ed: in_ready is high after Ed. The next accept is possible at Ed+1.
- Minimum issue interval is WN+2 cycles when out_ready is held high.
- Backpressure: DONE may last any number of cycles, with outputs held bit-stable.
- Outputs stay at their last values in IDLE/BUSY; only out_valid qualifies them.

## Test plan
- WN=16, WD=8: dividend=1000, divisor=7, m_i=0xA5 → quot=142, rem=6, div0=0, m_o=0xA5; out_valid exactly 16 edges after accept.
- WN=16, WD=8 edges: 65535/255 → quot=257, rem=0; 5/9 → quot=0, rem=5; 0x1234/1 → quot=0x1234, rem=0.
- Divide by zero, WN=16, WD=8: dividend=0x0312, divisor=0 → div0=1, quot=0xFFFF, rem=0x12.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid held, outputs constant, in_ready=0, extra in_valid pulses ignored. Then release → one handshake, in_ready=1 the next cycle, back-to-back ops at a WN+2 interval.
- Reset mid-op: assert rst at iteration 7 → no out_valid; in_ready=1 after release. A new op 200/13 → 15 r 5.
- Defaults WN=768, WD=384: feed the product of random 384-bit a·b with divisor b≠0 → quot=a, rem=0. Also feed a·b+c with c<b → quot=a, rem=c. Run 1000 random vectors against a reference model.
